// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for a 5-stage pipeline. Watches the ID-stage
// source registers, the ID/EX destination and memory-read flag, the EX branch
// outcome and data-memory busy. It then drives the hold/flush/bubble controls
// for PC, IF/ID, ID/EX and EX/MEM. It also tracks memory-wait timeout and
// keeps saturating stall and flush statistics.
//
// Parameters:
//   MAX_WAIT  longest legal consecutive mem_busy run (cycles); one more busy
//             cycle enters TIMEOUT
//   CNT_W     width of the stall_cnt / flush_cnt statistics counters
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst          in   synchronous active-high reset
//   id_src1      in   [4:0] ID-stage source register 1
//   id_src2      in   [4:0] ID-stage source register 2
//   id_two_src   in   ID instruction reads src2
//   ex_dest      in   [4:0] destination register in ID/EX
//   ex_mem_r_en  in   memory-read flag in ID/EX (load in EX)
//   br_taken     in   branch resolved taken in EX this cycle
//   mem_busy     in   data memory not ready this cycle
//   pc_hold      out  PC keeps its value
//   ifid_hold    out  IF/ID keeps its contents
//   ifid_flush   out  IF/ID loads a NOP
//   idex_bubble  out  ID/EX loads zero control fields
//   idex_hold    out  ID/EX keeps its contents
//   exmem_hold   out  EX/MEM keeps its contents
//   timeout_err  out  sticky memory-wait timeout flag
//   state        out  [1:0] FSM state: 0 RUN, 1 MEM_WAIT, 2 TIMEOUT
//   stall_cnt    out  [CNT_W-1:0] saturating count of pc_hold cycles
//   flush_cnt    out  [CNT_W-1:0] saturating count of branch-flush cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_src1,
   input  logic [4:0]       id_src2,
   input  logic             id_two_src,
   input  logic [4:0]       ex_dest,
   input  logic             ex_mem_r_en,
   input  logic             br_taken,
   input  logic             mem_busy,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             idex_hold,
   output logic             exmem_hold,
   output logic             timeout_err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Wide enough to hold MAX_WAIT itself.
   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TIMEOUT  = 2'd2
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic [WAIT_W-1:0] wait_cnt_next;
   logic [CNT_W-1:0]  stall_cnt_reg;
   logic [CNT_W-1:0]  flush_cnt_reg;

   logic load_use;
   logic flush_event;
   logic stall_event;

   // Load-use hazard: a load in EX whose destination feeds the ID
   // instruction. Register 0 is hard-wired zero and never creates a hazard.
   always_comb begin
      load_use = 1'b0;
      if (ex_mem_r_en && (ex_dest != 5'd0)) begin
         if (ex_dest == id_src1) begin
            load_use = 1'b1;
         end
         if (id_two_src && (ex_dest == id_src2)) begin
            load_use = 1'b1;
         end
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      pc_hold       = 1'b0;
      ifid_hold     = 1'b0;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      idex_hold     = 1'b0;
      exmem_hold    = 1'b0;
      timeout_err   = 1'b0;
      flush_event   = 1'b0;

      case (state_reg)
         ST_RUN: begin
            if (mem_busy) begin
               // Memory stall wins over everything: freeze the whole front.
               pc_hold       = 1'b1;
               ifid_hold     = 1'b1;
               idex_hold     = 1'b1;
               exmem_hold    = 1'b1;
               state_next    = ST_MEM_WAIT;
               wait_cnt_next = WAIT_W'(1);
            end else if (br_taken) begin
               // The ID instruction is wrong-path, so any hazard it shows
               // is irrelevant; squash IF/ID and ID/EX instead.
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               flush_event = 1'b1;
            end else if (load_use) begin
               // One-cycle stall: the bubble clears ex_mem_r_en next cycle,
               // which releases the hazard on its own.
               pc_hold     = 1'b1;
               ifid_hold   = 1'b1;
               idex_bubble = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            // While frozen, br_taken / load_use are ignored; the EX stage
            // re-presents them once the pipeline is running again.
            if (mem_busy) begin
               pc_hold    = 1'b1;
               ifid_hold  = 1'b1;
               idex_hold  = 1'b1;
               exmem_hold = 1'b1;
               if (wait_cnt_reg >= WAIT_W'(MAX_WAIT)) begin
                  state_next = ST_TIMEOUT;
               end else begin
                  wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
               end
            end else begin
               // Memory ready: holds drop in this same cycle.
               state_next    = ST_RUN;
               wait_cnt_next = '0;
            end
         end

         ST_TIMEOUT: begin
            // Terminal until reset.
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
            timeout_err = 1'b1;
         end

         default: begin
            state_next    = ST_RUN;
            wait_cnt_next = '0;
         end
      endcase

      // Reset masks every control output for its whole duration.
      if (rst) begin
         pc_hold     = 1'b0;
         ifid_hold   = 1'b0;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b0;
         idex_hold   = 1'b0;
         exmem_hold  = 1'b0;
         timeout_err = 1'b0;
         flush_event = 1'b0;
      end
   end

   // Statistics freeze in TIMEOUT even though pc_hold is asserted there.
   assign stall_event = pc_hold && (state_reg != ST_TIMEOUT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_RUN;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Saturating counters: stop at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (stall_event && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end
         if (flush_event && (flush_cnt_reg != {CNT_W{1'b1}})) begin
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign state     = state_reg;
   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl. A second instance
// with CNT_W=4 shares all inputs and is used for the saturation check.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_src1, id_src2, ex_dest;
   logic        id_two_src, ex_mem_r_en, br_taken, mem_busy;

   logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_hold;
   logic        timeout_err;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_hold, s_ifid_hold, s_ifid_flush, s_idex_bubble, s_idex_hold, s_exmem_hold;
   logic        s_timeout_err;
   logic [1:0]  s_state;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .ex_dest(ex_dest), .ex_mem_r_en(ex_mem_r_en),
      .br_taken(br_taken), .mem_busy(mem_busy), .pc_hold(pc_hold),
      .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .idex_hold(idex_hold), .exmem_hold(exmem_hold), .timeout_err(timeout_err),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .ex_dest(ex_dest), .ex_mem_r_en(ex_mem_r_en),
      .br_taken(br_taken), .mem_busy(mem_busy), .pc_hold(s_pc_hold),
      .ifid_hold(s_ifid_hold), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
      .idex_hold(s_idex_hold), .exmem_hold(s_exmem_hold), .timeout_err(s_timeout_err),
      .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   // Control vector order: {pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_hold}
   localparam logic [5:0] C_NONE   = 6'b000000;
   localparam logic [5:0] C_LU     = 6'b110100;
   localparam logic [5:0] C_FLUSH  = 6'b001100;
   localparam logic [5:0] C_FREEZE = 6'b110011;

   logic [5:0] ctrl;
   assign ctrl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_hold};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Apply inputs just after a rising edge and let combinational logic settle.
   task automatic drive(input logic r, input logic mb, input logic br,
                        input logic mre, input logic [4:0] dst,
                        input logic [4:0] s1, input logic [4:0] s2, input logic two);
      rst = r; mem_busy = mb; br_taken = br; ex_mem_r_en = mre;
      ex_dest = dst; id_src1 = s1; id_src2 = s2; id_two_src = two;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0);
      check("rst_ctrl_masked", 32'(ctrl), 32'(C_NONE));
      check("rst_timeout_masked", 32'(timeout_err), 0);
      tick();
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("reset_state", 32'(state), 0);
      check("reset_stall_cnt", 32'(stall_cnt), 0);
      check("reset_flush_cnt", 32'(flush_cnt), 0);
      check("idle_ctrl", 32'(ctrl), 32'(C_NONE));

      // Load-use on src1
      drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
      check("lu_src1_ctrl", 32'(ctrl), 32'(C_LU));
      tick();
      drive(0, 0, 0, 0, 5'd0, 5'd5, 5'd0, 0);
      check("lu_one_cycle", 32'(ctrl), 32'(C_NONE));
      check("lu_stall_cnt", 32'(stall_cnt), 1);

      // Register 0 never hazards
      drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
      check("lu_r0_ctrl", 32'(ctrl), 32'(C_NONE));
      tick();
      check("lu_r0_stall_cnt", 32'(stall_cnt), 1);

      // src2 gated by id_two_src
      drive(0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0);
      check("src2_gated_ctrl", 32'(ctrl), 32'(C_NONE));
      drive(0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1);
      check("src2_used_ctrl", 32'(ctrl), 32'(C_LU));
      tick();
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("src2_stall_cnt", 32'(stall_cnt), 2);

      // Branch beats load-use
      drive(0, 0, 1, 1, 5'd9, 5'd9, 5'd0, 0);
      check("br_over_lu_ctrl", 32'(ctrl), 32'(C_FLUSH));
      tick();
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("br_flush_cnt", 32'(flush_cnt), 1);
      check("br_stall_cnt_unchanged", 32'(stall_cnt), 2);

      // 15-cycle memory wait: legal, returns to RUN
      for (int i = 0; i < 15; i++) begin
         drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
         check($sformatf("mw_freeze_%0d", i), 32'(ctrl), 32'(C_FREEZE));
         check($sformatf("mw_state_%0d", i), 32'(state), (i == 0) ? 0 : 1);
         tick();
      end
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("mw_release_ctrl", 32'(ctrl), 32'(C_NONE));
      check("mw_release_state", 32'(state), 1);
      check("mw_no_timeout", 32'(timeout_err), 0);
      tick();
      check("mw_back_to_run", 32'(state), 0);
      check("mw_stall_cnt", 32'(stall_cnt), 17);
      check("mw_flush_cnt_unchanged", 32'(flush_cnt), 1);

      // 16 busy cycles: timeout
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
         tick();
      end
      check("to_state", 32'(state), 2);
      check("to_err", 32'(timeout_err), 1);
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("to_freeze_persists", 32'(ctrl), 32'(C_FREEZE));
      tick();
      check("to_state_sticky", 32'(state), 2);
      check("to_stall_cnt_frozen", 32'(stall_cnt), 33);
      drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("to_rst_ctrl", 32'(ctrl), 32'(C_NONE));
      check("to_rst_err", 32'(timeout_err), 0);
      tick();
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("post_rst_state", 32'(state), 0);
      check("post_rst_stall_cnt", 32'(stall_cnt), 0);
      check("post_rst_flush_cnt", 32'(flush_cnt), 0);
      check("post_rst_ctrl", 32'(ctrl), 32'(C_NONE));
      check("post_rst_small_cnt", 32'(s_stall_cnt), 0);

      // Saturation on the CNT_W=4 instance
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("sat_small_stall_cnt", 32'(s_stall_cnt), 15);
      check("sat_wide_stall_cnt", 32'(stall_cnt), 20);

      // Flush saturation on the small instance
      for (int i = 0; i < 18; i++) begin
         drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("sat_small_flush_cnt", 32'(s_flush_cnt), 15);
      check("sat_wide_flush_cnt", 32'(flush_cnt), 18);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule
